// File: rtl/cpuc_quad_ram_arb.sv
// ---------------------------------------------------------------------------
// cpuc_package / cpuc_quad_ram_arb
//
// Purpose
//   Round-robin arbiter that maps up to four requester transfers per cycle
//   onto the four ports (A..D) of the shared quad-port RAM. It refuses
//   same-cycle address hazards and returns registered read data one cycle
//   after the grant.
//
// Ports
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   req_valid/wren      per-requester request present / 1=write
//   req_addr/wdata      per-requester address and write data
//   req_ready           per-requester grant (combinational)
//   rsp_valid/rdata     read response, one cycle after a read grant
//   ram_address/wren/data  drive RAM ports A..D (index 0=A .. 3=D)
//   ram_q               RAM read data, combinational from ram_address
//   conflict_cnt        saturating count of cycles with a hazard refusal
//
// Handshake: a transfer happens in a cycle where req_valid[i] & req_ready[i]
// is 1. req_ready may depend on req_valid/req_wren/req_addr in the same
// cycle; req_valid must never depend on req_ready. Each handshake stands on
// its own, a requester may present a new request right after a grant.
// ---------------------------------------------------------------------------
package cpuc_package;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;
endpackage

module cpuc_quad_ram_arb
  import cpuc_package::*;
#(
  parameter int NUM_REQ = 8,
  parameter int CNT_W   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0]                   req_wren,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   rsp_rdata,
  output logic [3:0][ADDR_WIDTH-1:0]           ram_address,
  output logic [3:0]                           ram_wren,
  output logic [3:0][DATA_WIDTH-1:0]           ram_data,
  input  logic [3:0][DATA_WIDTH-1:0]           ram_q,
  output logic [CNT_W-1:0]                     conflict_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = IDX_W + 1;

  // Registered state
  logic [IDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]               rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]                 conflict_cnt_q, conflict_cnt_d;

  // Arbitration results for the current cycle
  logic [NUM_REQ-1:0]               grant;
  logic [3:0][ADDR_WIDTH-1:0]       port_addr;
  logic [3:0]                       port_wren;
  logic [3:0][DATA_WIDTH-1:0]       port_data;
  logic [3:0][IDX_W-1:0]            port_src;
  logic [2:0]                       n_grant;
  logic [IDX_W-1:0]                 last_idx;
  logic                             conflict;
  logic                             hazard;
  logic [SUM_W-1:0]                 sum;
  logic [IDX_W-1:0]                 idx;

  // Scan requesters from rr_ptr, filling port slots in grant order. A
  // hazard-refused request does not consume a slot; once four slots are
  // filled, later requests are simply not considered (and are not conflicts).
  always_comb begin
    grant     = '0;
    port_addr = '0;
    port_wren = '0;
    port_data = '0;
    port_src  = '0;
    n_grant   = '0;
    last_idx  = rr_ptr_q;
    conflict  = 1'b0;
    hazard    = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int s = 0; s < NUM_REQ; s++) begin
      sum = {1'b0, rr_ptr_q} + SUM_W'(s);
      if (sum >= SUM_W'(NUM_REQ)) begin
        sum = sum - SUM_W'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
      if (!rst && req_valid[idx] && (n_grant < 3'd4)) begin
        hazard = 1'b0;
        for (int k = 0; k < 4; k++) begin
          // writes clash with any granted access, reads only with writes
          if ((3'(k) < n_grant) && (port_addr[k] == req_addr[idx]) &&
              (req_wren[idx] || port_wren[k])) begin
            hazard = 1'b1;
          end
        end
        if (hazard) begin
          conflict = 1'b1;
        end else begin
          grant[idx]               = 1'b1;
          port_addr[n_grant[1:0]]  = req_addr[idx];
          port_wren[n_grant[1:0]]  = req_wren[idx];
          port_data[n_grant[1:0]]  = req_wren[idx] ? req_wdata[idx] : '0;
          port_src[n_grant[1:0]]   = idx;
          last_idx                 = idx;
          n_grant                  = n_grant + 3'd1;
        end
      end
    end
  end

  // Next-state for pointer, responses and counter
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    rsp_valid_d    = grant & ~req_wren;
    rsp_rdata_d    = rsp_rdata_q;
    conflict_cnt_d = conflict_cnt_q;
    if (grant != '0) begin
      rr_ptr_d = (last_idx == IDX_W'(NUM_REQ - 1)) ? '0 : last_idx + IDX_W'(1);
    end
    // ram_q is sampled at the grant edge, so reads see pre-write contents
    for (int k = 0; k < 4; k++) begin
      if ((3'(k) < n_grant) && !port_wren[k]) begin
        rsp_rdata_d[port_src[k]] = ram_q[k];
      end
    end
    if (conflict && (conflict_cnt_q != {CNT_W{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  // Async reset also discards a response owed for a grant just before reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      rsp_valid_q    <= '0;
      rsp_rdata_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign req_ready    = grant;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign ram_address  = port_addr;
  assign ram_wren     = port_wren;
  assign ram_data     = port_data;
  assign conflict_cnt = conflict_cnt_q;

endmodule
